// File: rtl/pong_button_conditioner_if.sv
// Paddle button bundle between the board pins and the conditioner.
// master drives the raw pins and receives the conditioned outputs; slave is the conditioner side.
interface pong_button_conditioner_if;
  logic [3:0] p_btn_raw;
  logic [3:0] p_btn_level;
  logic [3:0] p_btn_press;
  logic [3:0] p_btn_step;

  modport master (output p_btn_raw, input p_btn_level, input p_btn_press, input p_btn_step);
  modport slave  (input p_btn_raw, output p_btn_level, output p_btn_press, output p_btn_step);
endinterface

// File: rtl/pong_button_conditioner.sv
// Four-channel paddle button conditioner: sync, debounce, press edge, per-player conflict mask.
// Optional hold-to-repeat is built only when the macro AUTO_REPEAT_EN is defined.
//
// state  | meaning
// IDLE   | button released or press not yet seen; waiting for a press
// DELAY  | held; counting the initial delay before the first repeat step
// REPEAT | held; emitting a step every REPEAT_RATE cycles
module pong_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 17,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_RATE     = 1500000,
  parameter int RPT_W           = 23
) (
  input  logic                        p_clk12,
  input  logic                        p_rst,
  pong_button_conditioner_if.slave    btnIf
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 2**CNT_W ||
      REPEAT_RATE < 2 || REPEAT_DELAY < 1 || REPEAT_DELAY > 2**RPT_W) begin : gBadParams
    $error("pong_button_conditioner: illegal parameter combination");
  end

  logic [3:0]       syncS1, syncS2;
  logic [3:0]       level, press, step;
  logic [CNT_W-1:0] cnt    [4];
  logic [CNT_W-1:0] cntNxt [4];
  logic [3:0]       levelNxt, pressNxt, stepRaw, stepNxt;

  // Debounce: the level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    levelNxt = level;
    for (int i = 0; i < 4; i++) begin
      cntNxt[i] = '0;
      if (syncS2[i] != level[i]) begin
        if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          levelNxt[i] = syncS2[i];
        end else begin
          cntNxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  assign pressNxt = levelNxt & ~level;

  // Mask against the level that will be visible alongside the step, so a player
  // holding both directions never moves, including on the cycle both rise together.
  assign stepNxt = stepRaw & ~{ {2{levelNxt[2] & levelNxt[3]}}, {2{levelNxt[0] & levelNxt[1]}} };

  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      syncS1 <= '0;
      syncS2 <= '0;
      level  <= '0;
      press  <= '0;
      step   <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      syncS1 <= btnIf.p_btn_raw;
      syncS2 <= syncS1;
      level  <= levelNxt;
      press  <= pressNxt;
      step   <= stepNxt;
      for (int i = 0; i < 4; i++) cnt[i] <= cntNxt[i];
    end
  end

`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rptState_t;

  rptState_t        state    [4];
  rptState_t        stateNxt [4];
  logic [RPT_W-1:0] tmr      [4];
  logic [RPT_W-1:0] tmrNxt   [4];

  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        tmr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= stateNxt[i];
        tmr[i]   <= tmrNxt[i];
      end
    end
  end

  // Release is tested first so the cycle the level drops never carries a step.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stateNxt[i] = state[i];
      tmrNxt[i]   = tmr[i];
      case (state[i])
        IDLE: begin
          if (pressNxt[i]) begin
            stateNxt[i] = DELAY;
            tmrNxt[i]   = '0;
          end
        end
        DELAY: begin
          if (!levelNxt[i]) begin
            stateNxt[i] = IDLE;
          end else if (tmr[i] == RPT_W'(REPEAT_DELAY - 1)) begin
            stateNxt[i] = REPEAT;
            tmrNxt[i]   = '0;
          end else begin
            tmrNxt[i] = tmr[i] + 1'b1;
          end
        end
        REPEAT: begin
          if (!levelNxt[i]) begin
            stateNxt[i] = IDLE;
          end else if (tmr[i] == RPT_W'(REPEAT_RATE - 1)) begin
            tmrNxt[i] = '0;
          end else begin
            tmrNxt[i] = tmr[i] + 1'b1;
          end
        end
        default: begin
          stateNxt[i] = IDLE;
          tmrNxt[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stepRaw = '0;
    for (int i = 0; i < 4; i++) begin
      case (state[i])
        IDLE:    stepRaw[i] = pressNxt[i];
        DELAY:   stepRaw[i] = levelNxt[i] && (tmr[i] == RPT_W'(REPEAT_DELAY - 1));
        REPEAT:  stepRaw[i] = levelNxt[i] && (tmr[i] == RPT_W'(REPEAT_RATE - 1));
        default: stepRaw[i] = 1'b0;
      endcase
    end
  end
`else
  assign stepRaw = pressNxt;
`endif

  assign btnIf.p_btn_level = level;
  assign btnIf.p_btn_press = press;
  assign btnIf.p_btn_step  = step;

endmodule
